// File: rtl/instruction_writeback_mc_if.sv
// Writeback stage bundle: retiring-instruction handshake, load data bus, and
// register-file write / status outputs.
interface instruction_writeback_mc_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned RET_W = 64
);
    localparam int unsigned RD_W = $clog2(NREG);

    logic [31:0]      t_instr;
    logic             t_instr_valid;
    logic             t_instr_ready;
    logic [XLEN-1:0]  iPC;
    logic [XLEN-1:0]  maAlu_rdValue;
    logic [XLEN-1:0]  dbus_rdata;
    logic             dbus_rvalid;
    logic             we;
    logic [RD_W-1:0]  rd;
    logic [XLEN-1:0]  rdValue;
    logic             misalign;
    logic [RET_W-1:0] instret;

    // Upstream pipeline plus data bus side.
    modport master (
        output t_instr, t_instr_valid, iPC, maAlu_rdValue, dbus_rdata, dbus_rvalid,
        input  t_instr_ready, we, rd, rdValue, misalign, instret
    );

    // Writeback stage side.
    modport slave (
        input  t_instr, t_instr_valid, iPC, maAlu_rdValue, dbus_rdata, dbus_rvalid,
        output t_instr_ready, we, rd, rdValue, misalign, instret
    );
endinterface

// File: rtl/instruction_writeback_mc.sv
// Multi-cycle writeback stage: accepts one retiring instruction per handshake,
// picks its result, waits for load data when needed and issues one registered
// register-file write. Misaligned loads are dropped with a misalign pulse.
module instruction_writeback_mc #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned RET_W = 64
) (
    input logic                      clk,
    input logic                      rstf,
    instruction_writeback_mc_if.slave wb
);
    localparam int unsigned RD_W   = $clog2(NREG);
    localparam int unsigned LANE_W = $clog2(XLEN / 8);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpJal   = 7'b1101111;

    localparam logic StIdle     = 1'b0;
    localparam logic StWaitLoad = 1'b1;

    logic              state_q, state_d;
    logic              we_q, we_d;
    logic              mis_q, mis_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   val_q, val_d;
    logic [RET_W-1:0]  instret_q, instret_d;
    logic [RD_W-1:0]   ld_rd_q, ld_rd_d;
    logic [2:0]        ld_funct3_q, ld_funct3_d;
    logic [LANE_W-1:0] ld_lane_q, ld_lane_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [RD_W-1:0]   rd_field;
    logic [2:0]        addr_lo;
    logic              xfer;
    logic              load_ok;
    logic              load_mis;
    logic              writes_rd;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_data;
    logic              unused_instr_hi;

    assign opcode          = wb.t_instr[6:0];
    assign funct3          = wb.t_instr[14:12];
    assign rd_field        = wb.t_instr[7 +: RD_W];
    assign addr_lo         = wb.maAlu_rdValue[2:0];
    assign unused_instr_hi = ^wb.t_instr[31:15];

    assign wb.t_instr_ready = (state_q == StIdle) & ~rstf;
    assign xfer             = wb.t_instr_valid & wb.t_instr_ready;

    assign wb.we      = we_q;
    assign wb.rd      = rd_q;
    assign wb.rdValue = val_q;
    assign wb.misalign = mis_q;
    assign wb.instret = instret_q;

    // Decode: result source for non-loads, legality and alignment for loads.
    always_comb begin
        writes_rd  = 1'b0;
        alu_result = wb.maAlu_rdValue;
        unique case (opcode)
            OpJal, OpJalr: begin
                writes_rd  = 1'b1;
                alu_result = wb.iPC + XLEN'(4);
            end
            OpLui, OpAuipc, OpReg, OpImm: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase

        load_ok  = 1'b0;
        load_mis = 1'b0;
        unique case (funct3)
            3'b000, 3'b100: load_ok = 1'b1;
            3'b001, 3'b101: begin
                load_ok  = 1'b1;
                load_mis = addr_lo[0];
            end
            3'b010: begin
                load_ok  = 1'b1;
                load_mis = |addr_lo[1:0];
            end
            3'b110: begin
                load_ok  = (XLEN == 64);
                load_mis = |addr_lo[1:0];
            end
            3'b011: begin
                load_ok  = (XLEN == 64);
                load_mis = |addr_lo;
            end
            default: load_ok = 1'b0;
        endcase
    end

    // Load formatting: move the addressed lane to bit 0, then extend.
    always_comb begin
        shifted = wb.dbus_rdata >> {ld_lane_q, 3'b000};
        unique case (ld_funct3_q)
            3'b000:  load_data = XLEN'($signed(shifted[7:0]));
            3'b001:  load_data = XLEN'($signed(shifted[15:0]));
            3'b010:  load_data = XLEN'($signed(shifted[31:0]));
            3'b100:  load_data = XLEN'(shifted[7:0]);
            3'b101:  load_data = XLEN'(shifted[15:0]);
            3'b110:  load_data = XLEN'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

    // Next-state: completions, load capture and the IDLE/WAIT_LOAD sequencing.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        mis_d       = 1'b0;
        rd_d        = rd_q;
        val_d       = val_q;
        instret_d   = instret_q;
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        ld_lane_d   = ld_lane_q;

        if (state_q == StIdle) begin
            if (xfer) begin
                if (opcode == OpLoad && load_ok && !load_mis) begin
                    state_d     = StWaitLoad;
                    ld_rd_d     = rd_field;
                    ld_funct3_d = funct3;
                    ld_lane_d   = wb.maAlu_rdValue[LANE_W-1:0];
                end else begin
                    // Misaligned or unsupported loads retire without a write.
                    instret_d = instret_q + RET_W'(1);
                    if (opcode == OpLoad) begin
                        mis_d = load_ok;
                    end else if (writes_rd && rd_field != '0) begin
                        we_d  = 1'b1;
                        rd_d  = rd_field;
                        val_d = alu_result;
                    end
                end
            end
        end else if (wb.dbus_rvalid) begin
            state_d   = StIdle;
            instret_d = instret_q + RET_W'(1);
            if (ld_rd_q != '0) begin
                we_d  = 1'b1;
                rd_d  = ld_rd_q;
                val_d = load_data;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rstf) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            rd_q        <= '0;
            val_q       <= '0;
            instret_q   <= '0;
            ld_rd_q     <= '0;
            ld_funct3_q <= '0;
            ld_lane_q   <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            mis_q       <= mis_d;
            rd_q        <= rd_d;
            val_q       <= val_d;
            instret_q   <= instret_d;
            ld_rd_q     <= ld_rd_d;
            ld_funct3_q <= ld_funct3_d;
            ld_lane_q   <= ld_lane_d;
        end
    end
endmodule

// File: tb/tb_instruction_writeback_mc.sv
// Bench for instruction_writeback_mc: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_instruction_writeback_mc;
    localparam logic [6:0] OP_LOAD = 7'h03, OP_IMM = 7'h13, OP_AUIPC = 7'h17, OP_STORE = 7'h23;
    localparam logic [6:0] OP_REG = 7'h33, OP_LUI = 7'h37, OP_BRANCH = 7'h63, OP_JALR = 7'h67;
    localparam logic [6:0] OP_JAL = 7'h6F, OP_SYSTEM = 7'h73, OP_FENCE = 7'h0F, OP_BAD = 7'h7F;

    logic clk;
    logic rstf;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 0;

    instruction_writeback_mc_if #(.XLEN(32), .NREG(32), .RET_W(64)) wb ();

    instruction_writeback_mc #(.XLEN(32), .NREG(32), .RET_W(64)) dut (
        .clk  (clk),
        .rstf (rstf),
        .wb   (wb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model state: what the stage's outputs must be after each clock edge.
    bit          m_busy = 0;
    bit          m_xfer = 0;
    logic [4:0]  m_ldrd = '0;
    logic [2:0]  m_ldf3 = '0;
    int          m_ldlane = 0;
    logic        m_we = 0, m_mis = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_val = '0;
    logic [63:0] m_instret = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt(logic [2:0] f3, int lane, logic [31:0] d);
        longint unsigned w, b, h;
        w = d;
        w = w >> (8 * lane);
        b = w % 256;
        h = w % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF0000) : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return 32'(w);
        endcase
    endfunction

    function automatic int align_need(logic [2:0] f3);
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        if (f3 == 3'd2) return 4;
        return 1;
    endfunction

    // Applies the effect of one clock edge, given the inputs presented at it.
    task automatic model_edge();
        logic [6:0] op;
        logic [4:0] r;
        logic [2:0] f3;
        m_xfer = 0;
        if (rstf) begin
            m_busy = 0; m_we = 0; m_mis = 0; m_instret = '0; m_rd = '0; m_val = '0;
            return;
        end
        m_we  = 0;
        m_mis = 0;
        if (!m_busy) begin
            if (wb.t_instr_valid) begin
                m_xfer = 1;
                op = wb.t_instr[6:0];
                r  = wb.t_instr[11:7];
                f3 = wb.t_instr[14:12];
                if (op == OP_LOAD) begin
                    if ((wb.maAlu_rdValue % align_need(f3)) != 0) begin
                        m_mis = 1;
                        m_instret++;
                    end else begin
                        m_busy   = 1;
                        m_ldrd   = r;
                        m_ldf3   = f3;
                        m_ldlane = int'(wb.maAlu_rdValue % 4);
                    end
                end else begin
                    m_instret++;
                    if (r != 0 && (op == OP_JAL || op == OP_JALR || op == OP_LUI ||
                                   op == OP_AUIPC || op == OP_REG || op == OP_IMM)) begin
                        m_we  = 1;
                        m_rd  = r;
                        m_val = (op == OP_JAL || op == OP_JALR) ? wb.iPC + 32'd4
                                                                : wb.maAlu_rdValue;
                    end
                end
            end
        end else if (wb.dbus_rvalid) begin
            m_busy = 0;
            m_instret++;
            if (m_ldrd != 0) begin
                m_we  = 1;
                m_rd  = m_ldrd;
                m_val = fmt(m_ldf3, m_ldlane, wb.dbus_rdata);
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 64'(wb.t_instr_ready), 64'(!m_busy && !rstf));
            check("we", 64'(wb.we), 64'(m_we));
            check("misalign", 64'(wb.misalign), 64'(m_mis));
            check("rd", 64'(wb.rd), 64'(m_rd));
            check("rdValue", 64'(wb.rdValue), 64'(m_val));
            check("instret", wb.instret, m_instret);
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] r, logic [2:0] f3);
        logic [31:0] x;
        x = $urandom;
        x[14:0] = {f3, r, op};
        return x;
    endfunction

    task automatic issue(logic [31:0] instr, logic [31:0] pc, logic [31:0] alu);
        bit done;
        done = 0;
        wb.t_instr       = instr;
        wb.iPC           = pc;
        wb.maAlu_rdValue = alu;
        wb.t_instr_valid = 1'b1;
        for (int k = 0; k < 8 && !done; k++) begin
            cycle();
            done = m_xfer;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL xfer_timeout: got no transfer expected transfer at %0t", $time);
        end
        wb.t_instr_valid = 1'b0;
    endtask

    task automatic do_load(logic [31:0] instr, logic [31:0] addr, int wait_n, logic [31:0] d);
        issue(instr, $urandom, addr);
        if (m_busy) begin
            for (int w = 0; w < wait_n; w++) begin
                wb.dbus_rvalid = 1'b0;
                wb.dbus_rdata  = $urandom;
                cycle();
            end
            wb.dbus_rvalid = 1'b1;
            wb.dbus_rdata  = d;
            cycle();
            wb.dbus_rvalid = 1'b0;
        end
    endtask

    logic [6:0] ops [12] = '{OP_LOAD, OP_LOAD, OP_LOAD, OP_IMM, OP_REG, OP_LUI, OP_AUIPC,
                             OP_JAL, OP_JALR, OP_BRANCH, OP_STORE, OP_SYSTEM};
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        logic [6:0] op;
        logic [4:0] r;
        rstf             = 1'b1;
        wb.t_instr       = '0;
        wb.t_instr_valid = 1'b0;
        wb.iPC           = '0;
        wb.maAlu_rdValue = '0;
        wb.dbus_rdata    = '0;
        wb.dbus_rvalid   = 1'b0;

        // Reset held two cycles.
        cycle();
        chk_en = 1;
        cycle();
        check("rst_instret", wb.instret, 64'd0);
        check("rst_ready", 64'(wb.t_instr_ready), 64'd0);
        check("rst_we", 64'(wb.we), 64'd0);
        rstf = 1'b0;
        #1;
        check("ready_after_rst", 64'(wb.t_instr_ready), 64'd1);

        // ALU writes, including rd = x0.
        issue(mk(OP_IMM, 5'd5, 3'd0), 32'h100, 32'h1234);
        check("addi_we", 64'(wb.we), 64'd1);
        check("addi_rd", 64'(wb.rd), 64'd5);
        check("addi_val", 64'(wb.rdValue), 64'h1234);
        check("addi_instret", wb.instret, 64'd1);
        issue(mk(OP_IMM, 5'd0, 3'd0), 32'h104, 32'h1234);
        check("addi_x0_we", 64'(wb.we), 64'd0);
        check("addi_x0_instret", wb.instret, 64'd2);

        // JAL link wraps; branch retires without a write.
        issue(mk(OP_JAL, 5'd1, 3'd0), 32'hFFFF_FFFC, 32'h55);
        check("jal_we", 64'(wb.we), 64'd1);
        check("jal_val", 64'(wb.rdValue), 64'h0);
        issue(mk(OP_BRANCH, 5'd9, 3'd0), 32'h200, 32'h66);
        check("beq_we", 64'(wb.we), 64'd0);
        check("beq_instret", wb.instret, 64'd4);

        // Load formatting.
        do_load(mk(OP_LOAD, 5'd7, 3'd0), 32'h0000_1003, 3, 32'h80FF_FFFF);
        check("lb_we", 64'(wb.we), 64'd1);
        check("lb_val", 64'(wb.rdValue), 64'hFFFF_FF80);
        do_load(mk(OP_LOAD, 5'd7, 3'd4), 32'h0000_1003, 1, 32'h80FF_FFFF);
        check("lbu_val", 64'(wb.rdValue), 64'h0000_0080);
        do_load(mk(OP_LOAD, 5'd8, 3'd5), 32'h0000_1002, 0, 32'h80FF_FFFF);
        check("lhu_val", 64'(wb.rdValue), 64'h0000_80FF);
        check("lhu_instret", wb.instret, 64'd7);

        // Misaligned LW, then back-to-back ALU ops.
        do_load(mk(OP_LOAD, 5'd3, 3'd2), 32'h0000_1002, 2, 32'h1);
        check("mis_pulse", 64'(wb.misalign), 64'd1);
        check("mis_we", 64'(wb.we), 64'd0);
        check("mis_ready", 64'(wb.t_instr_ready), 64'd1);
        check("mis_instret", wb.instret, 64'd8);
        for (int i = 1; i <= 4; i++) begin
            wb.t_instr       = mk(OP_REG, 5'(i), 3'd0);
            wb.maAlu_rdValue = 32'(i * 16'h1111);
            wb.t_instr_valid = 1'b1;
            cycle();
            check("b2b_we", 64'(wb.we), 64'd1);
            check("b2b_val", 64'(wb.rdValue), 64'(i * 16'h1111));
        end
        wb.t_instr_valid = 1'b0;

        // Reset while waiting for load data.
        issue(mk(OP_LOAD, 5'd4, 3'd2), 32'h300, 32'h0000_2000);
        rstf = 1'b1;
        cycle();
        rstf = 1'b0;
        wb.dbus_rvalid = 1'b1;
        wb.dbus_rdata  = 32'hDEAD_BEEF;
        cycle();
        wb.dbus_rvalid = 1'b0;
        check("rstload_we", 64'(wb.we), 64'd0);
        check("rstload_instret", wb.instret, 64'd0);
        check("rstload_ready", 64'(wb.t_instr_ready), 64'd1);

        // Randomized traffic with idle gaps, stray rvalid and occasional resets.
        for (int i = 0; i < 300; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                wb.dbus_rvalid = ($urandom_range(0, 3) == 0);
                wb.dbus_rdata  = $urandom;
                cycle();
            end
            wb.dbus_rvalid = 1'b0;
            if (i % 97 == 50) begin
                rstf = 1'b1;
                cycle();
                rstf = 1'b0;
            end
            op = ($urandom_range(0, 15) == 0) ? OP_BAD : ops[$urandom_range(0, 11)];
            r  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            if (op == OP_LOAD)
                do_load(mk(op, r, ld_f3[$urandom_range(0, 4)]), $urandom,
                        $urandom_range(0, 3), $urandom);
            else
                issue(mk(op, r, 3'($urandom)), $urandom, $urandom);
        end
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
